// File: rtl/wb_burst_master_pkg.sv
// wb_burst_master_pkg
// Shared types and constants for the Wishbone burst initiator:
//   - state_e      : FSM states of the burst master
//   - CTI_*        : Wishbone B3 cycle type identifier encodings
//   - ERR_CNT_W    : width of the read-mismatch counter
//   - BEAT_IDX_W   : width of the beat index (cmd_len is beats minus one)
//   - beat_cti()   : CTI to present for a beat, given whether it is the last
package wb_burst_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ERR_CNT_W  = 16;
  localparam int BEAT_IDX_W = 8;

  function automatic logic [2:0] beat_cti(input logic final_beat);
    return final_beat ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_pattern_gen.sv
// wb_pattern_gen
// Running data pattern shared by the write path and the read-compare path.
// The registered word always equals seed + idx (mod 2^dw).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : start a new pattern at seed, index 0
//   advance   : step to the next beat (word + 1, idx + 1)
//   seed      : pattern seed captured on load
//   word      : current pattern word (registered)
//   idx       : current beat index (registered)
module wb_pattern_gen
  import wb_burst_master_pkg::*;
#(
  parameter int dw = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [dw-1:0]         seed,
  output logic [dw-1:0]         word,
  output logic [BEAT_IDX_W-1:0] idx
);

  logic [dw-1:0]         word_q, word_d;
  logic [BEAT_IDX_W-1:0] idx_q, idx_d;

  // Load wins over advance so a new command always starts cleanly.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load) begin
      word_d = seed;
      idx_d  = '0;
    end else if (advance) begin
      word_d = word_q + dw'(1);
      idx_d  = idx_q + BEAT_IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word = word_q;
  assign idx  = idx_q;

endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master
// Wishbone B3 incrementing-burst initiator for SDRAM bring-up. Accepts one
// command at a time, writes a seed-based pattern or reads it back and counts
// mismatches. All outputs are registered.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_write/addr/len/seed     : burst direction, start byte address,
//                                 beats minus one, pattern seed
//   wb_cyc_o/stb_o/we_o/addr_o/dat_o/sel_o/cti_o, wb_ack_i, wb_dat_i
//                               : Wishbone master port
//   done                        : one-cycle pulse at end of each command
//   timeout                     : command aborted for lack of ack (sticky)
//   err_cnt, first_err_addr     : read mismatch count and first bad address
// Optional feature: define WB_BURST_MASTER_TIMEOUT_EN to abort a burst after
// TIMEOUT consecutive cycles without ack; otherwise XFER waits forever and
// timeout is tied low.
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int dw         = 32,
  parameter int app_addr_w = 26,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [app_addr_w-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [dw-1:0]         cmd_seed,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [app_addr_w-1:0] wb_addr_o,
  output logic [dw-1:0]         wb_dat_o,
  output logic [dw/8-1:0]       wb_sel_o,
  output logic [2:0]            wb_cti_o,
  input  logic                  wb_ack_i,
  input  logic [dw-1:0]         wb_dat_i,
  output logic                  done,
  output logic                  timeout,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [app_addr_w-1:0] first_err_addr
);

  state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  done_q, done_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [dw/8-1:0]       sel_q, sel_d;
  logic [2:0]            cti_q, cti_d;
  logic [app_addr_w-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [app_addr_w-1:0] first_err_addr_q, first_err_addr_d;
  logic                  timeout_q, timeout_d;

  logic                  accept, beat_ack, last_beat, abort;
  logic [dw-1:0]         pat_word;
  logic [BEAT_IDX_W-1:0] pat_idx;

  assign accept    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  assign beat_ack  = (state_q == XFER) && wb_ack_i;
  assign last_beat = (pat_idx == len_q);

  wb_pattern_gen #(.dw(dw)) u_pattern (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (accept),
    .advance (beat_ack && !last_beat),
    .seed    (cmd_seed),
    .word    (pat_word),
    .idx     (pat_idx)
  );

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive ack-less XFER cycles; abort fires once the count has
  // reached TIMEOUT and this cycle still has no ack.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept || beat_ack) begin
      tmo_cnt_d = '0;
    end else if (state_q == XFER) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign abort = (state_q == XFER) && !wb_ack_i && (tmo_cnt_q == TMO_W'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = XFER;
      XFER:    if ((beat_ack && last_beat) || abort) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of every registered output, derived from the
  // state being entered so the bus signals line up with state_q.
  always_comb begin
    cmd_ready_d      = (state_d == IDLE);
    done_d           = (state_d == RESP);
    cyc_d            = (state_d == XFER);
    sel_d            = (state_d == XFER) ? '1 : '0;
    we_d             = we_q;
    cti_d            = cti_q;
    addr_d           = addr_q;
    len_d            = len_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    timeout_d        = timeout_q;

    if (accept) begin
      we_d             = cmd_write;
      addr_d           = cmd_addr;
      len_d            = cmd_len;
      cti_d            = beat_cti(cmd_len == 8'd0);
      err_cnt_d        = '0;
      first_err_addr_d = '0;
      timeout_d        = 1'b0;
    end

    if (beat_ack) begin
      // err_cnt saturates, so a zero count marks the first mismatch.
      if (!we_q && (wb_dat_i != pat_word)) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (err_cnt_q == '0) first_err_addr_d = addr_q;
      end
      if (!last_beat) begin
        addr_d = addr_q + app_addr_w'(dw / 8);
        cti_d  = beat_cti((pat_idx + BEAT_IDX_W'(1)) == len_q);
      end
    end

    if (abort) timeout_d = 1'b1;

    if (state_d != XFER) begin
      we_d  = 1'b0;
      cti_d = CTI_CLASSIC;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready_q      <= 1'b0;
      done_q           <= 1'b0;
      cyc_q            <= 1'b0;
      we_q             <= 1'b0;
      sel_q            <= '0;
      cti_q            <= CTI_CLASSIC;
      addr_q           <= '0;
      len_q            <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      timeout_q        <= 1'b0;
    end else begin
      cmd_ready_q      <= cmd_ready_d;
      done_q           <= done_d;
      cyc_q            <= cyc_d;
      we_q             <= we_d;
      sel_q            <= sel_d;
      cti_q            <= cti_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      timeout_q        <= timeout_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign done           = done_q;
  assign wb_cyc_o       = cyc_q;
  assign wb_stb_o       = cyc_q;
  assign wb_we_o        = we_q;
  assign wb_sel_o       = sel_q;
  assign wb_cti_o       = cti_q;
  assign wb_addr_o      = addr_q;
  assign wb_dat_o       = pat_word;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
  assign timeout        = timeout_q;
`else
  assign timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master
// Scoreboard bench for wb_burst_master: each scenario pushes the beats it
// expects, a Wishbone slave task records the beats the master presents, and
// the scenario pops and compares both queues. Define
// WB_BURST_MASTER_TIMEOUT_EN to also exercise the ack timeout (TIMEOUT=16).
module tb_wb_burst_master;

  localparam int DW = 32;
  localparam int AW = 26;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          we;
    logic [2:0]    cti;
    logic [3:0]    sel;
  } beat_t;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] cmd_seed = '0;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;
  logic          done, timeout_o;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int unstable = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  wb_burst_master #(.dw(DW), .app_addr_w(AW), .TIMEOUT(16)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (wb_rst_i),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_seed       (cmd_seed),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_addr_o      (wb_addr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_cti_o       (wb_cti_o),
    .wb_ack_i       (wb_ack_i),
    .wb_dat_i       (wb_dat_i),
    .done           (done),
    .timeout        (timeout_o),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Reference model of a burst: address steps by 4 with wrap, data is
  // seed + k, CTI marks the last beat as end-of-burst.
  task automatic expect_burst(input logic w, input logic [AW-1:0] a,
                              input int len, input logic [DW-1:0] s);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.addr = a + AW'(4 * k);
      b.dat  = s + DW'(k);
      b.we   = w;
      b.cti  = (k == len) ? 3'b111 : 3'b010;
      b.sel  = 4'hF;
      exp_q.push_back(b);
    end
  endtask

  // Waits (bounded) for cmd_ready, then presents the command for one edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] l,
                       input logic [DW-1:0] s, output bit ok);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = cmd_ready;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_seed = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wishbone slave: acks after 'waits' stall cycles, records presented beats,
  // stores writes, returns stored data on reads (flipping bit 8 on beats set
  // in 'corrupt'), and counts bus changes while a beat is stalled.
  task automatic serve(input int nbeats, input int waits, input logic [31:0] corrupt);
    int got = 0;
    int wcnt = 0;
    beat_t cur, held;
    logic [DW-1:0] rd;
    held = '0;
    for (int c = 0; c < 3000 && got < nbeats; c++) begin
      wb_ack_i = 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        cur.addr = wb_addr_o; cur.dat = wb_dat_o; cur.we = wb_we_o;
        cur.cti  = wb_cti_o;  cur.sel = wb_sel_o;
        if (wcnt == 0) held = cur;
        else if (cur !== held) unstable++;
        if (wcnt == waits) begin
          obs_q.push_back(cur);
          if (cur.we) begin
            mem[cur.addr] = cur.dat;
          end else begin
            rd = mem.exists(cur.addr) ? mem[cur.addr] : 32'hDEAD_BEEF;
            if (corrupt[got]) rd = rd ^ 32'h0000_0100;
            wb_dat_i = rd;
          end
          wb_ack_i = 1'b1;
          got++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk); #1;
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o, cmd_ready, done, timeout_o, err_cnt, first_err_addr} !== '0)
      $display("[TB] FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h cti=%b addr=%h dat=%h rdy=%b done=%b to=%b err=%h fea=%h, all required 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o, cmd_ready, done, timeout_o, err_cnt, first_err_addr);
    else n_pass++;
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_burst();
    bit ok;
    beat_t e, o;
    expect_burst(1'b1, 26'h100, 3, 32'hA5A5_0000);
    issue(1'b1, 26'h100, 8'd3, 32'hA5A5_0000, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL wr4_accept: cmd_ready never seen, required 1");
    else n_pass++;
    serve(4, 0, 32'h0);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL wr4_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("[TB] FAIL wr4_beat: got addr=%h dat=%h we=%b cti=%b sel=%h required addr=%h dat=%h we=%b cti=%b sel=%h",
                            o.addr, o.dat, o.we, o.cti, o.sel, e.addr, e.dat, e.we, e.cti, e.sel);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if ({done, wb_cyc_o, wb_stb_o, cmd_ready, timeout_o} !== 5'b10000)
      $display("[TB] FAIL wr4_done: done/cyc/stb/rdy/to=%b required 10000", {done, wb_cyc_o, wb_stb_o, cmd_ready, timeout_o});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, cmd_ready} !== 2'b01) $display("[TB] FAIL wr4_after: done/rdy=%b required 01", {done, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_read_waits();
    bit ok;
    beat_t e, o;
    unstable = 0;
    expect_burst(1'b0, 26'h100, 3, 32'hA5A5_0000);
    issue(1'b0, 26'h100, 8'd3, 32'hA5A5_0000, ok);
    serve(4, 2, 32'h0);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL rd4_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("[TB] FAIL rd4_beat: got addr=%h dat=%h we=%b cti=%b required addr=%h dat=%h we=%b cti=%b",
                            o.addr, o.dat, o.we, o.cti, e.addr, e.dat, e.we, e.cti);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (unstable !== 0) $display("[TB] FAIL rd4_stable: %0d changes while stalled, required 0", unstable);
    else n_pass++;
    n_checks++;
    if ({done, err_cnt, first_err_addr} !== {1'b1, 16'd0, 26'd0})
      $display("[TB] FAIL rd4_result: done=%b err=%0d fea=%h required done=1 err=0 fea=0", done, err_cnt, first_err_addr);
    else n_pass++;
  endtask

  task automatic test_read_errors();
    bit ok;
    beat_t e, o;
    logic [31:0] corrupt;
    int exp_err;
    logic [AW-1:0] exp_fea;
    corrupt = 32'h0000_0024;
    exp_err = 0;
    exp_fea = '0;
    for (int k = 7; k >= 0; k--) begin
      if (corrupt[k]) begin
        exp_err++;
        exp_fea = 26'h200 + AW'(4 * k);
      end
    end
    expect_burst(1'b1, 26'h200, 7, 32'h1234_5678);
    expect_burst(1'b0, 26'h200, 7, 32'h1234_5678);
    issue(1'b1, 26'h200, 8'd7, 32'h1234_5678, ok);
    serve(8, 0, 32'h0);
    issue(1'b0, 26'h200, 8'd7, 32'h1234_5678, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL rd8_accept: cmd_ready never seen, required 1");
    else n_pass++;
    serve(8, 1, corrupt);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL rd8_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("[TB] FAIL rd8_beat: got addr=%h dat=%h we=%b cti=%b required addr=%h dat=%h we=%b cti=%b",
                            o.addr, o.dat, o.we, o.cti, e.addr, e.dat, e.we, e.cti);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    n_checks++;
    if (err_cnt !== 16'(exp_err)) $display("[TB] FAIL rd8_err_cnt: got %0d required %0d", err_cnt, exp_err);
    else n_pass++;
    n_checks++;
    if (first_err_addr !== exp_fea) $display("[TB] FAIL rd8_first_addr: got %h required %h", first_err_addr, exp_fea);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    beat_t e, o;
    expect_burst(1'b1, 26'h3FF_FFFC, 0, 32'hCAFE_0000);
    issue(1'b1, 26'h3FF_FFFC, 8'd0, 32'hCAFE_0000, ok);
    serve(1, 0, 32'h0);
    n_checks++;
    if (done !== 1'b1) $display("[TB] FAIL single_done: done=%b required 1", done);
    else n_pass++;
    expect_burst(1'b1, 26'h3FF_FFFC, 1, 32'hBEEF_0010);
    issue(1'b1, 26'h3FF_FFFC, 8'd1, 32'hBEEF_0010, ok);
    serve(2, 0, 32'h0);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("[TB] FAIL wrap_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("[TB] FAIL wrap_beat: got addr=%h dat=%h cti=%b required addr=%h dat=%h cti=%b",
                            o.addr, o.dat, o.cti, e.addr, e.dat, e.cti);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    beat_t e, o;
    int done_seen = 0;
    expect_burst(1'b1, 26'h400, 15, 32'h0F0F_0000);
    issue(1'b1, 26'h400, 8'd15, 32'h0F0F_0000, ok);
    serve(3, 0, 32'h0);
    for (int k = 0; k < 3 && exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("[TB] FAIL rst16_beat: got addr=%h dat=%h required addr=%h dat=%h", o.addr, o.dat, e.addr, e.dat);
      else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, done} !== 3'b000) $display("[TB] FAIL rst16_drop: cyc/stb/done=%b required 000", {wb_cyc_o, wb_stb_o, done});
    else n_pass++;
    wb_rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) $display("[TB] FAIL rst16_no_done: done seen %0d times required 0", done_seen);
    else n_pass++;
    n_checks++;
    if ({cmd_ready, wb_cyc_o} !== 2'b10) $display("[TB] FAIL rst16_ready: rdy/cyc=%b required 10", {cmd_ready, wb_cyc_o});
    else n_pass++;
  endtask

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int high = 0;
    issue(1'b0, 26'h800, 8'd3, 32'h5555_0000, ok);
    while (wb_cyc_o && high < 200) begin
      high++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (high !== 17) $display("[TB] FAIL tmo_cycles: cyc high %0d cycles required 17", high);
    else n_pass++;
    n_checks++;
    if ({done, timeout_o} !== 2'b11) $display("[TB] FAIL tmo_flags: done/timeout=%b required 11", {done, timeout_o});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({done, timeout_o, cmd_ready} !== 3'b011) $display("[TB] FAIL tmo_sticky: done/timeout/rdy=%b required 011", {done, timeout_o, cmd_ready});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_read_waits();
    test_read_errors();
    test_wrap();
    test_reset_mid_burst();
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
